unpack_max_scan: RTL

//  Downstream consumer of the 20-entry x 11-bit unpacked register array. On request,

---
 rtl/unpack_max_scan.sv | 120 ++++++++++++
 1 files changed

// File: rtl/unpack_max_scan.sv
// Find-max scanner: walks every entry of an external register array through its
// combinational read port, one entry per clock, and reports the largest value and its index.
module unpack_max_scan #(
    parameter int DEPTH = 20,
    parameter int WIDTH = 11,
    parameter int AW    = 5
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             start,
    output logic [AW-1:0]    rd_idx,
    input  logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] max_val,
    output logic [AW-1:0]    max_idx,
    output logic [1:0]       o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [AW-1:0]    r_rd_idx;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_max_val;
    logic [AW-1:0]    r_max_idx;
    logic [WIDTH-1:0] r_cur_val;
    logic [AW-1:0]    r_cur_idx;

    logic             w_last;
    logic             w_take;
    logic [WIDTH-1:0] w_cmp_val;
    logic [AW-1:0]    w_cmp_idx;
    logic [AW-1:0]    w_rd_idx_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;

    assign w_last = (r_rd_idx == LAST_IDX);

    // Entry 0 seeds the running max; later entries replace it only when strictly larger,
    // so the lowest index wins ties.
    assign w_take    = (r_rd_idx == '0) || (rd_data > r_cur_val);
    assign w_cmp_val = w_take ? rd_data  : r_cur_val;
    assign w_cmp_idx = w_take ? r_rd_idx : r_cur_idx;

    always_ff @(posedge ck) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_state_nxt = S_SCAN;
            S_SCAN:  if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy_nxt   = (w_state_nxt != S_IDLE);
        w_done_nxt   = (w_state_nxt == S_DONE);
        w_rd_idx_nxt = '0;
        if (r_state == S_SCAN && !w_last) begin
            w_rd_idx_nxt = r_rd_idx + AW'(1);
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            r_rd_idx  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_max_val <= '0;
            r_max_idx <= '0;
            r_cur_val <= '0;
            r_cur_idx <= '0;
        end else begin
            r_rd_idx <= w_rd_idx_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            case (r_state)
                S_IDLE: begin
                    r_cur_val <= '0;
                    r_cur_idx <= '0;
                end
                S_SCAN: begin
                    r_cur_val <= w_cmp_val;
                    r_cur_idx <= w_cmp_idx;
                    // Published results only move when a scan completes.
                    if (w_last) begin
                        r_max_val <= w_cmp_val;
                        r_max_idx <= w_cmp_idx;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rd_idx      = r_rd_idx;
    assign busy        = r_busy;
    assign done        = r_done;
    assign max_val     = r_max_val;
    assign max_idx     = r_max_idx;
    assign o_dbg_state = r_state;

endmodule
